gate_checker: RTL and testbench
===============================

GATE_CHECKER -- requirements
Module: gate_checker

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 2; drive-to-sample wait per vector in clock cycles; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  run request; accepted only in IDLE.
REQ-005 drv_in1  output  1  stimulus to gate-under-test input 1.
REQ-006 drv_in2  output  1  stimulus to gate-under-test input 2.
REQ-007 and_in, or_in, not_in, nand_in, nor_in, xor_in, xnor_in  input  1 each  observed gate outputs.
REQ-008 busy  output  1  high from the cycle after start acceptance through the last SAMPLE cycle.
REQ-009 done  output  1  one-cycle pulse at run completion.
REQ-010 pass  output  1  high when the completed run found no mismatch.
REQ-011 fail_mask  output  7  sticky per-gate mismatch bits: [0]and [1]or [2]not [3]nand [4]nor [5]xor [6]xnor.
REQ-012 vec_idx  output  2  index of the vector currently driven.

Function
REQ-013 FSM states SHALL be IDLE, DRIVE, SAMPLE, DONE.
REQ-014 IDLE: start=1 -> DRIVE with vec_idx=0, settle counter=0, fail_mask and pass cleared.
REQ-015 Vector order: 0..3; drv_in1=vec_idx[1], drv_in2=vec_idx[0], registered, stable for the whole vector.
REQ-016 DRIVE: lasts exactly SETTLE_CYCLES cycles, counter increments each cycle, then -> SAMPLE.
REQ-017 SAMPLE: one cycle; each observed input compared to expected; mismatch bits OR-ed into fail_mask.
REQ-018 Expected values: and=a&b, or=a|b, not=~a (in2 ignored), nand, nor, xor, xnor of (drv_in1, drv_in2).
REQ-019 SAMPLE with vec_idx<3 -> DRIVE, vec_idx+1, counter=0; with vec_idx=3 -> DONE.
REQ-020 DONE: one cycle; done=1; pass=(fail_mask==0) registered; -> IDLE.
REQ-021 Latency: DONE entered exactly 4*(SETTLE_CYCLES+1) clock edges after the start-accepting edge (12 at default).
REQ-022 start while not in IDLE SHALL be ignored, with no effect on state or results.
REQ-023 start high in the DONE cycle SHALL be ignored; start held high into IDLE begins a new run.
REQ-024 pass and fail_mask hold their values from DONE until the next start acceptance.
REQ-025 In IDLE, drv_in1=drv_in2=0 and vec_idx=0.
REQ-026 Observed inputs SHALL be sampled only in SAMPLE; glitches in DRIVE have no effect.

Reset
REQ-027 reset=1 SHALL force IDLE at the next edge from any state, including mid-run, with priority over start.
REQ-028 Reset values: drv_in1=0, drv_in2=0, busy=0, done=0, pass=0, fail_mask=0, vec_idx=0, counter=0.
REQ-029 A run interrupted by reset SHALL NOT produce a done pulse.

Structure
REQ-030 Shared package gate_checker_pkg SHALL hold the state enum, fail_mask bit-index constants, and a function returning the 7-bit expected vector for (a, b).
REQ-031 One sub-module, gate_golden, SHALL compute the 7 expected outputs combinationally from drv_in1/drv_in2; no other hierarchy.
REQ-032 All outputs SHALL be driven directly from registers.

Verification
REQ-033 Correct gate model attached, SETTLE_CYCLES=2, start pulse -> done high exactly 12 cycles after accepting edge, pass=1, fail_mask=7'b0000000.
REQ-034 xor_in stuck at 0 -> mismatches on vectors 1 and 2; fail_mask=7'b0100000, pass=0.
REQ-035 not_in wired to drv_in1 -> fail_mask=7'b0000100; nand_in/nor_in swapped -> fail_mask=7'b0011000.
REQ-036 start re-pulsed at cycles 3 and 8 of a run -> ignored; exactly one done pulse at cycle 12.
REQ-037 reset asserted at cycle 5 of a run -> next cycle busy=0, drv_in1=drv_in2=0, fail_mask=0, no done pulse.
REQ-038 Failing run followed by run against correct model -> second run clears fail_mask at start; ends pass=1, fail_mask=0.

Source files
------------

// File: rtl/gate_checker_pkg.sv
// ----------------------------------------------------------------------------
// gate_checker_pkg
// Shared definitions for the gate checker: the FSM state encoding, the bit
// positions of each gate inside the 7-bit result/mismatch vectors, and the
// golden truth function for the seven two-input (or one-input) gates.
// ----------------------------------------------------------------------------
package gate_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Bit positions inside fail_mask and the expected/observed vectors
    localparam int unsigned FM_AND  = 0;
    localparam int unsigned FM_OR   = 1;
    localparam int unsigned FM_NOT  = 2;
    localparam int unsigned FM_NAND = 3;
    localparam int unsigned FM_NOR  = 4;
    localparam int unsigned FM_XOR  = 5;
    localparam int unsigned FM_XNOR = 6;
    localparam int unsigned NUM_GATES = 7;

    // Expected gate outputs for stimulus (a, b); NOT only looks at a
    function automatic logic [6:0] gate_expect(input logic a, input logic b);
        logic [6:0] e;
        e          = 7'd0;
        e[FM_AND]  = a & b;
        e[FM_OR]   = a | b;
        e[FM_NOT]  = ~a;
        e[FM_NAND] = ~(a & b);
        e[FM_NOR]  = ~(a | b);
        e[FM_XOR]  = a ^ b;
        e[FM_XNOR] = ~(a ^ b);
        return e;
    endfunction

endpackage

// File: rtl/gate_golden.sv
// ----------------------------------------------------------------------------
// gate_golden
// Purely combinational reference model of the seven gates under test.
// Ports:
//   in1_i, in2_i : stimulus bits currently driven to the gates
//   expect_o     : expected outputs, bit order as in gate_checker_pkg FM_*
// ----------------------------------------------------------------------------
module gate_golden
    import gate_checker_pkg::*;
(
    input  logic       in1_i,
    input  logic       in2_i,
    output logic [6:0] expect_o
);

    assign expect_o = gate_expect(in1_i, in2_i);

endmodule

// File: rtl/gate_checker.sv
// ----------------------------------------------------------------------------
// gate_checker
// Exercises an external set of seven logic gates with the four input vectors
// (00, 01, 10, 11), waits SETTLE_CYCLES per vector, samples the gate outputs
// once per vector and accumulates per-gate mismatch bits.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : run request, honoured only in IDLE
//   drv_in1, drv_in2    : stimulus to the gates (registered)
//   and_in .. xnor_in   : observed gate outputs
//   busy                : run in progress (DRIVE/SAMPLE)
//   done                : one-cycle completion pulse
//   pass                : last completed run had no mismatch
//   fail_mask           : sticky per-gate mismatch bits
//   vec_idx             : index of the vector being driven
// ----------------------------------------------------------------------------
module gate_checker
    import gate_checker_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       drv_in1,
    output logic       drv_in2,
    input  logic       and_in,
    input  logic       or_in,
    input  logic       not_in,
    input  logic       nand_in,
    input  logic       nor_in,
    input  logic       xor_in,
    input  logic       xnor_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] fail_mask,
    output logic [1:0] vec_idx
);

    // Counter value of the final DRIVE cycle of a vector
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic       drv1_q, drv1_d;
    logic       drv2_q, drv2_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [6:0] fail_mask_q, fail_mask_d;

    logic [6:0] expected_s;
    logic [6:0] observed_s;
    logic [6:0] mismatch_s;
    logic [1:0] next_vec_s;

    gate_golden u_golden (
        .in1_i    (drv1_q),
        .in2_i    (drv2_q),
        .expect_o (expected_s)
    );

    assign observed_s = {xnor_in, xor_in, nor_in, nand_in, not_in, or_in, and_in};
    assign mismatch_s = observed_s ^ expected_s;
    assign next_vec_s = vec_q + 2'd1;

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            vec_q       <= 2'd0;
            cnt_q       <= 4'd0;
            drv1_q      <= 1'b0;
            drv2_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= 7'd0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            drv1_q      <= drv1_d;
            drv2_q      <= drv2_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_mask_q <= fail_mask_d;
        end
    end

    // Next-state and next-output logic for the run sequencer
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        drv1_d      = drv1_q;
        drv2_d      = drv2_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        fail_mask_d = fail_mask_q;

        case (state_q)
            ST_IDLE: begin
                vec_d  = 2'd0;
                cnt_d  = 4'd0;
                drv1_d = 1'b0;
                drv2_d = 1'b0;
                if (start) begin
                    state_d     = ST_DRIVE;
                    busy_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_mask_d = 7'd0;
                end else begin
                    busy_d = 1'b0;
                end
            end

            ST_DRIVE: begin
                // Counter advances every DRIVE cycle; the last one hands over
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    state_d = ST_DRIVE;
                end
            end

            ST_SAMPLE: begin
                // Only here do the observed gate outputs affect any state
                fail_mask_d = fail_mask_q | mismatch_s;
                cnt_d       = 4'd0;
                if (vec_q == 2'd3) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = ((fail_mask_q | mismatch_s) == 7'd0);
                    vec_d   = 2'd0;
                    drv1_d  = 1'b0;
                    drv2_d  = 1'b0;
                end else begin
                    state_d = ST_DRIVE;
                    vec_d   = next_vec_s;
                    drv1_d  = next_vec_s[1];
                    drv2_d  = next_vec_s[0];
                end
            end

            ST_DONE: begin
                // start is deliberately not looked at here
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign drv_in1   = drv1_q;
    assign drv_in2   = drv2_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_mask = fail_mask_q;
    assign vec_idx   = vec_q;

endmodule

// File: tb/tb_gate_checker.sv
// ----------------------------------------------------------------------------
// tb_gate_checker
// Drives gate_checker against a behavioural gate model with selectable faults.
// Expected run results are queued when a run is started and popped when the
// done pulse is due.
// ----------------------------------------------------------------------------
module tb_gate_checker;

    localparam int S         = 2;
    localparam int RUN_EDGES = 4 * (S + 1);

    typedef struct packed {
        logic [6:0] mask;
        logic       exp_pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       drv_in1, drv_in2;
    logic       and_in, or_in, not_in, nand_in, nor_in, xor_in, xnor_in;
    logic       busy, done, pass;
    logic [6:0] fail_mask;
    logic [1:0] vec_idx;

    int   fault_mode = 0;   // 0 good, 1 xor stuck 0, 2 not=drv_in1, 3 nand/nor swapped
    logic glitch_en  = 1'b0;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    gate_checker #(.SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .drv_in1   (drv_in1),
        .drv_in2   (drv_in2),
        .and_in    (and_in),
        .or_in     (or_in),
        .not_in    (not_in),
        .nand_in   (nand_in),
        .nor_in    (nor_in),
        .xor_in    (xor_in),
        .xnor_in   (xnor_in),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_mask (fail_mask),
        .vec_idx   (vec_idx)
    );

    // Behavioural gates under test, with fault injection and DRIVE-time glitches
    always_comb begin
        and_in  = drv_in1 & drv_in2;
        or_in   = drv_in1 | drv_in2;
        not_in  = ~drv_in1;
        nand_in = ~(drv_in1 & drv_in2);
        nor_in  = ~(drv_in1 | drv_in2);
        xor_in  = drv_in1 ^ drv_in2;
        xnor_in = ~(drv_in1 ^ drv_in2);
        case (fault_mode)
            1: xor_in = 1'b0;
            2: not_in = drv_in1;
            3: begin
                nand_in = ~(drv_in1 | drv_in2);
                nor_in  = ~(drv_in1 & drv_in2);
            end
            default: ;
        endcase
        if (glitch_en) begin
            and_in  = ~and_in;
            or_in   = ~or_in;
            not_in  = ~not_in;
            nand_in = ~nand_in;
            nor_in  = ~nor_in;
            xor_in  = ~xor_in;
            xnor_in = ~xnor_in;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({busy, done, pass, fail_mask, vec_idx, drv_in1, drv_in2} !== 14'd0) begin
            n_err++;
            $display("FAIL reset_values: got %b required %b",
                     {busy, done, pass, fail_mask, vec_idx, drv_in1, drv_in2}, 14'd0);
        end
        reset = 1'b0;
        start = 1'b0;
        tick();
        n_vec++;
        if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL idle_after_reset: busy/done got %b required 00", {busy, done});
        end
    endtask

    // One full run: per-cycle drive/busy checks, done timing and result checks
    task automatic run_check(input string name, input int mode, input logic [6:0] exp_mask,
                             input logic exp_pass, input bit repulse, input bit glitch);
        exp_t       e;
        logic [1:0] v;
        int         p;
        fault_mode = mode;
        e.mask     = exp_mask;
        e.exp_pass = exp_pass;
        sb_q.push_back(e);
        start = 1'b1;
        tick();                 // accepting edge
        start = 1'b0;
        for (int j = 0; j < RUN_EDGES; j++) begin
            v = 2'(j / (S + 1));
            p = j % (S + 1);
            n_vec++;
            if ({busy, done, vec_idx, drv_in1, drv_in2} !== {1'b1, 1'b0, v, v[1], v[0]}) begin
                n_err++;
                $display("FAIL %s_seq edge %0d: busy,done,vec,drv got %b required %b",
                         name, j, {busy, done, vec_idx, drv_in1, drv_in2},
                         {1'b1, 1'b0, v, v[1], v[0]});
            end
            if (j == 0) begin
                n_vec++;
                if ({pass, fail_mask} !== 8'd0) begin
                    n_err++;
                    $display("FAIL %s_clear_at_start: pass,fail_mask got %b required %b",
                             name, {pass, fail_mask}, 8'd0);
                end
            end
            start     = repulse && (j == 3 || j == 8);
            glitch_en = glitch && (p < S);
            tick();
        end
        start     = 1'b0;
        glitch_en = 1'b0;
        e = sb_q.pop_front();
        n_vec++;
        if ({done, busy, pass, fail_mask} !== {1'b1, 1'b0, e.exp_pass, e.mask}) begin
            n_err++;
            $display("FAIL %s_done: done,busy,pass,fail_mask got %b required %b",
                     name, {done, busy, pass, fail_mask}, {1'b1, 1'b0, e.exp_pass, e.mask});
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_vec++;
            if ({done, busy, pass, fail_mask, vec_idx, drv_in1, drv_in2} !==
                {1'b0, 1'b0, e.exp_pass, e.mask, 2'b00, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL %s_hold %0d: got %b required %b", name, k,
                         {done, busy, pass, fail_mask, vec_idx, drv_in1, drv_in2},
                         {1'b0, 1'b0, e.exp_pass, e.mask, 2'b00, 1'b0, 1'b0});
            end
        end
    endtask

    // start held high: ignored in DONE, accepted again once back in IDLE
    task automatic test_start_held();
        exp_t e;
        bit   seen;
        int   k;
        fault_mode = 0;
        e.mask = 7'd0; e.exp_pass = 1'b1;
        sb_q.push_back(e);
        start = 1'b1;
        tick();
        for (int j = 0; j < RUN_EDGES; j++) tick();
        e = sb_q.pop_front();
        n_vec++;
        if ({done, pass, fail_mask} !== {1'b1, e.exp_pass, e.mask}) begin
            n_err++;
            $display("FAIL held_first_done: got %b required %b",
                     {done, pass, fail_mask}, {1'b1, e.exp_pass, e.mask});
        end
        fault_mode = 1;
        tick();                 // DONE -> IDLE, start ignored
        n_vec++;
        if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL held_done_ignored: busy,done got %b required 00", {busy, done});
        end
        e.mask = 7'b0100000; e.exp_pass = 1'b0;
        sb_q.push_back(e);
        tick();                 // IDLE accepts held start
        start = 1'b0;
        n_vec++;
        if ({busy, fail_mask, pass} !== {1'b1, 7'd0, 1'b0}) begin
            n_err++;
            $display("FAIL held_restart: busy,fail_mask,pass got %b required %b",
                     {busy, fail_mask, pass}, {1'b1, 7'd0, 1'b0});
        end
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 40) begin
            tick();
            if (done) seen = 1'b1;
            else k++;
        end
        e = sb_q.pop_front();
        n_vec++;
        if (!seen || k != RUN_EDGES - 1 || {pass, fail_mask} !== {e.exp_pass, e.mask}) begin
            n_err++;
            $display("FAIL held_second_done: seen=%0d edges=%0d pass,mask=%b required edges=%0d %b",
                     seen, k + 1, {pass, fail_mask}, RUN_EDGES, {e.exp_pass, e.mask});
        end
        tick();
        tick();
    endtask

    task automatic test_reset_midrun();
        bit bad;
        fault_mode = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 4; j++) tick();
        n_vec++;
        if ({busy, fail_mask} !== {1'b1, 7'b0000100}) begin
            n_err++;
            $display("FAIL midrun_before_reset: busy,fail_mask got %b required %b",
                     {busy, fail_mask}, {1'b1, 7'b0000100});
        end
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        n_vec++;
        if ({busy, done, pass, fail_mask, vec_idx, drv_in1, drv_in2} !== 14'd0) begin
            n_err++;
            $display("FAIL midrun_reset: got %b required %b",
                     {busy, done, pass, fail_mask, vec_idx, drv_in1, drv_in2}, 14'd0);
        end
        bad = 1'b0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL midrun_no_done: saw busy/done after reset, required none");
        end
        fault_mode = 0;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        test_reset();
        run_check("good",        0, 7'b0000000, 1'b1, 1'b0, 1'b0);
        run_check("xor_stuck",   1, 7'b0100000, 1'b0, 1'b0, 1'b0);
        run_check("not_fault",   2, 7'b0000100, 1'b0, 1'b0, 1'b0);
        run_check("nand_nor",    3, 7'b0011000, 1'b0, 1'b0, 1'b0);
        run_check("repulse",     0, 7'b0000000, 1'b1, 1'b1, 1'b0);
        run_check("glitch",      0, 7'b0000000, 1'b1, 1'b0, 1'b1);
        test_start_held();
        test_reset_midrun();
        run_check("b2b_fail",    1, 7'b0100000, 1'b0, 1'b0, 1'b0);
        run_check("b2b_pass",    0, 7'b0000000, 1'b1, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
